branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 111 +++++++++++
 tb/tb_branch_predictor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: 2-bit saturating BHT plus tagged direct-mapped BTB,
// with EX-stage resolution producing the redirect and branch/mispredict counters.
module branch_predictor #(
    parameter int IDX_BITS = 4,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = PC_W - IDX_BITS - 2;

    logic [1:0]         cnt_q   [ENTRIES];
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q   [ENTRIES];
    logic [PC_W-1:0]    tgt_q   [ENTRIES];
    logic [31:0]        br_count_q, br_count_d;
    logic [31:0]        mp_count_q, mp_count_d;

    logic [IDX_BITS-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0]    fetch_tag, upd_tag;
    logic                hit, mispredict;
    logic [1:0]          cnt_d;
    logic                unused_fetch_lsb;

    assign fetch_idx        = fetch_pc[IDX_BITS+1:2];
    assign fetch_tag        = fetch_pc[PC_W-1:IDX_BITS+2];
    assign upd_idx          = upd_pc[IDX_BITS+1:2];
    assign upd_tag          = upd_pc[PC_W-1:IDX_BITS+2];
    assign unused_fetch_lsb = ^fetch_pc[1:0];

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign hit         = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_taken  = hit && cnt_q[fetch_idx][1];
    assign pred_target = pred_taken ? tgt_q[fetch_idx] : '0;

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    always_comb begin
        redirect    = mispredict;
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);
        end
    end

    always_comb begin
        cnt_d      = cnt_q[upd_idx];
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (upd_valid) begin
            br_count_d = br_count_q + 32'd1;
            if (mispredict) begin
                mp_count_d = mp_count_q + 32'd1;
            end
            if (upd_taken) begin
                if (cnt_q[upd_idx] != 2'b11) cnt_d = cnt_q[upd_idx] + 2'b01;
            end else begin
                if (cnt_q[upd_idx] != 2'b00) cnt_d = cnt_q[upd_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= 2'b01;
            end
            valid_q    <= '0;
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
            if (upd_valid) begin
                cnt_q[upd_idx] <= cnt_d;
                if (upd_taken) begin
                    valid_q[upd_idx] <= 1'b1;
                end
            end
        end
    end

    // Tag/target need no reset: they are only observed behind a set valid bit.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a table-level behavioural model.
module tb_branch_predictor;

    localparam int PC_W = 32;
    localparam int N    = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] fetch_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            upd_pred_taken;
    logic [PC_W-1:0] upd_pred_target;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0]     br_count;
    logic [31:0]     mp_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    branch_predictor #(.IDX_BITS(4), .PC_W(PC_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .br_count        (br_count),
        .mp_count        (mp_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: one record per table entry, integer counter 0..3
    int          m_cnt [N];
    bit          m_vld [N];
    logic [31:0] m_tag [N];
    logic [31:0] m_tgt [N];
    logic [31:0] m_br, m_mp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit m_mis();
        if (!upd_valid) return 1'b0;
        if (upd_pred_taken != upd_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 1;
                m_vld[i] = 1'b0;
            end
            m_br = 0;
            m_mp = 0;
        end else if (upd_valid) begin
            int k;
            k = idx_of(upd_pc);
            m_br = m_br + 1;
            if (m_mis()) m_mp = m_mp + 1;
            if (upd_taken) begin
                m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
                m_vld[k] = 1'b1;
                m_tag[k] = tag_of(upd_pc);
                m_tgt[k] = upd_target;
            end else begin
                m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
            end
        end
    end

    // compare process, sampled on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            bit e_pt;
            logic [31:0] e_rpc;
            k = idx_of(fetch_pc);
            e_pt = m_vld[k] && (m_tag[k] == tag_of(fetch_pc)) && (m_cnt[k] >= 2);
            e_rpc = !m_mis() ? 32'h0 : (upd_taken ? upd_target : upd_pc + 32'd4);
            chk("model_pred_taken", {31'b0, pred_taken}, {31'b0, e_pt});
            chk("model_pred_target", pred_target, e_pt ? m_tgt[k] : 32'h0);
            chk("model_redirect", {31'b0, redirect}, {31'b0, m_mis()});
            chk("model_redirect_pc", redirect_pc, e_rpc);
            chk("model_br_count", br_count, m_br);
            chk("model_mp_count", mp_count, m_mp);
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input bit v, input logic [31:0] pc, input bit t,
                           input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
        upd_valid       = v;
        upd_pc          = pc;
        upd_taken       = t;
        upd_target      = tg;
        upd_pred_taken  = pt;
        upd_pred_target = ptg;
    endtask

    logic [31:0] pc_set  [6];
    logic [31:0] tgt_set [4];

    initial begin
        pc_set  = '{32'h100, 32'h140, 32'h204, 32'h180, 32'h3fc, 32'hFFFF_FFFC};
        tgt_set = '{32'h200, 32'h240, 32'h300, 32'h0};
        rst = 1'b1;
        fetch_pc = 32'h100;
        set_upd(0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("reset_br_count", br_count, 32'h0);
        next_cycle();
        rst = 1'b1;
        #2;
        chk("idle_pred_taken_0x100", {31'b0, pred_taken}, 32'h0);
        chk("idle_pred_target_0x100", pred_target, 32'h0);

        // first taken branch allocates, lookup in the same cycle sees old state
        next_cycle();
        set_upd(1, 32'h100, 1, 32'h200, 0, 32'h0);
        #2;
        chk("alloc_redirect", {31'b0, redirect}, 32'h1);
        chk("alloc_redirect_pc", redirect_pc, 32'h200);
        chk("alloc_no_bypass", {31'b0, pred_taken}, 32'h0);
        next_cycle();
        set_upd(0, 0, 0, 0, 0, 0);
        #2;
        chk("alloc_mp_count", mp_count, 32'h1);
        chk("alloc_br_count", br_count, 32'h1);
        chk("alloc_pred_taken", {31'b0, pred_taken}, 32'h1);
        chk("alloc_pred_target", pred_target, 32'h200);

        // not-taken training down to saturation at 00
        next_cycle();
        set_upd(1, 32'h100, 0, 32'h200, 1, 32'h200);
        #2;
        chk("nt_redirect_pc", redirect_pc, 32'h104);
        next_cycle();
        set_upd(1, 32'h100, 0, 32'h0, 0, 32'h0);
        #2;
        chk("nt_correct_redirect", {31'b0, redirect}, 32'h0);
        chk("nt_weak_pred", {31'b0, pred_taken}, 32'h0);
        next_cycle();
        next_cycle();
        set_upd(1, 32'h100, 1, 32'h200, 0, 32'h0);
        #2;
        chk("sat_low_pred", {31'b0, pred_taken}, 32'h0);
        next_cycle();
        #2;
        chk("after_sat_one_taken", {31'b0, pred_taken}, 32'h0);
        next_cycle();
        set_upd(0, 0, 0, 0, 0, 0);
        #2;
        chk("retrained_pred", {31'b0, pred_taken}, 32'h1);
        chk("seq_br_count", br_count, 32'd6);
        chk("seq_mp_count", mp_count, 32'd4);

        // aliasing: same index, different tag
        fetch_pc = 32'h140;
        #1;
        chk("alias_miss", {31'b0, pred_taken}, 32'h0);
        next_cycle();
        set_upd(1, 32'h140, 1, 32'h300, 0, 32'h0);
        next_cycle();
        set_upd(0, 0, 0, 0, 0, 0);
        fetch_pc = 32'h100;
        #2;
        chk("evicted_miss", {31'b0, pred_taken}, 32'h0);
        next_cycle();
        fetch_pc = 32'h140;
        #2;
        chk("evictor_hit", {31'b0, pred_taken}, 32'h1);
        chk("evictor_target", pred_target, 32'h300);

        // wrong target on a correctly predicted taken branch
        next_cycle();
        fetch_pc = 32'h204;
        set_upd(1, 32'h204, 1, 32'h240, 1, 32'h200);
        #2;
        chk("tgt_redirect", {31'b0, redirect}, 32'h1);
        chk("tgt_redirect_pc", redirect_pc, 32'h240);
        next_cycle();
        set_upd(0, 0, 0, 0, 0, 0);
        #2;
        chk("tgt_new_target", pred_target, 32'h240);

        // fall-through PC wraps at the top of the address space
        next_cycle();
        set_upd(1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10);
        #2;
        chk("wrap_redirect_pc", redirect_pc, 32'h0);

        // fresh reset, build br_count=5, then asynchronous reset mid-cycle
        next_cycle();
        set_upd(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            set_upd(1, 32'h100, 1, 32'h200, 0, 32'h0);
        end
        next_cycle();
        set_upd(0, 0, 0, 0, 0, 0);
        fetch_pc = 32'h100;
        #2;
        chk("pre_async_br_count", br_count, 32'd5);
        chk("pre_async_pred", {31'b0, pred_taken}, 32'h1);
        rst = 1'b0;
        #1;
        chk("async_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("async_pred_target", pred_target, 32'h0);
        chk("async_br_count", br_count, 32'h0);
        chk("async_mp_count", mp_count, 32'h0);
        next_cycle();
        rst = 1'b1;

        // randomized traffic, checked by the compare process every cycle
        for (int i = 0; i < 800; i++) begin
            logic [31:0] tg;
            next_cycle();
            tg = tgt_set[$urandom_range(0, 3)];
            if (tg == 32'h0) tg = $urandom & 32'hFFFF_FFFC;
            fetch_pc = pc_set[$urandom_range(0, 5)];
            set_upd($urandom_range(0, 1), pc_set[$urandom_range(0, 5)], $urandom_range(0, 1),
                    tg, $urandom_range(0, 1),
                    ($urandom_range(0, 1) != 0) ? tg : tgt_set[$urandom_range(0, 3)]);
        end
        next_cycle();
        set_upd(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
